// File: rtl/nand4_response_checker.sv
// Checks a 4-input NAND gate's response over ordered sweeps of all 16
// input patterns, and counts errors in the order and in the response.
//
// Ports:
//   clk, rst      : clock, async active-high reset
//   start         : run request (honoured in IDLE/DONE)
//   valid         : sample strobe; a..d stimulus (P={d,c,b,a}), y response
//   busy/done     : RUN / DONE indication
//   pass/fail     : verdict in DONE
//   err_count     : saturating error count
//   first_fail    : P of first erroneous sample
//   sweep_count   : completed 16-pattern sweeps
module nand4_response_checker #(
  parameter int NUM_SWEEPS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [4:0] err_count,
  output logic [3:0] first_fail,
  output logic [3:0] sweep_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] NS = 4'(NUM_SWEEPS);

  state_t     state, state_n;
  logic [3:0] exp_idx, exp_n;
  logic [4:0] err_n;
  logic [3:0] ff_n;
  logic [3:0] sw_n;
  logic       seen, seen_n;
  logic       busy_n, done_n, pass_n, fail_n;
  logic [3:0] pat;
  logic       smp_err;

  assign pat = {d, c, b, a};

  // Expected response comes from the received pattern, so an order
  // error alone does not also look like a response error.
  assign smp_err = (pat != exp_idx) | (y != ~(&pat));

  always_comb begin
    state_n = state;
    exp_n   = exp_idx;
    err_n   = err_count;
    ff_n    = first_fail;
    sw_n    = sweep_count;
    seen_n  = seen;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          exp_n   = 4'd0;
          err_n   = 5'd0;
          ff_n    = 4'd0;
          sw_n    = 4'd0;
          seen_n  = 1'b0;
        end
      end
      RUN: begin
        if (valid) begin
          exp_n = exp_idx + 4'd1;
          if (smp_err) begin
            if (err_count != 5'd31)
              err_n = err_count + 5'd1;
            if (!seen) begin
              ff_n   = pat;
              seen_n = 1'b1;
            end
          end
          if (exp_idx == 4'd15) begin
            sw_n = sweep_count + 4'd1;
            if (sw_n == NS)
              state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
    pass_n = done_n && (err_n == 5'd0);
    fail_n = done_n && (err_n != 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      exp_idx     <= 4'd0;
      err_count   <= 5'd0;
      first_fail  <= 4'd0;
      sweep_count <= 4'd0;
      seen        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_n;
      exp_idx     <= exp_n;
      err_count   <= err_n;
      first_fail  <= ff_n;
      sweep_count <= sw_n;
      seen        <= seen_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      fail        <= fail_n;
    end
  end

endmodule

// File: doc/nand4_response_checker.md
NAND4_RESPONSE_CHECKER -- requirements
Module: nand4_response_checker

Interface
REQ-001 The block SHALL have parameter NUM_SWEEPS, default 1, giving the number of complete 16-pattern sweeps checked per run (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: run request, sampled in IDLE and DONE only.
REQ-005 The block SHALL have port valid, input, 1 bit: stimulus/response sample strobe, one sample per high cycle.
REQ-006 The block SHALL have ports a, b, c, d, input, 1 bit each: stimulus applied to the gate under test; pattern value P = {d,c,b,a} (a = LSB).
REQ-007 The block SHALL have port y, input, 1 bit: observed gate response.
REQ-008 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-010 The block SHALL have port pass, output, 1 bit: high in DONE when err_count = 0.
REQ-011 The block SHALL have port fail, output, 1 bit: high in DONE when err_count != 0.
REQ-012 The block SHALL have port err_count, output, 5 bits: errors detected this run, saturating.
REQ-013 The block SHALL have port first_fail, output, 4 bits: P of the first erroneous sample this run.
REQ-014 The block SHALL have port sweep_count, output, 4 bits: completed sweeps this run.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE: start = 1 SHALL move to RUN next edge, clearing exp_idx (4 bits), err_count, first_fail, sweep_count, and the first-error flag.
REQ-017 RUN: valid = 0 SHALL hold all state; start SHALL be ignored.
REQ-018 RUN, valid = 1: a sample SHALL be erroneous if P != exp_idx (order error) or y != ~(a&b&c&d) (response error); both together count as one error.
REQ-019 Expected response SHALL be computed from the received P, not from exp_idx.
REQ-020 On an erroneous sample err_count SHALL increment by 1, saturating at 31 (no wrap).
REQ-021 first_fail SHALL capture P only on the first erroneous sample of a run and hold thereafter.
REQ-022 Each valid sample SHALL increment exp_idx modulo 16 (15 -> 0), even after an order error; no resynchronisation.
REQ-023 A valid sample with exp_idx = 15 SHALL increment sweep_count; when the new value equals NUM_SWEEPS the FSM SHALL enter DONE on the same edge.
REQ-024 Updates from a sample SHALL be visible on outputs one cycle after the valid cycle (latency 1).
REQ-025 DONE: done = 1, pass/fail per REQ-010/011; outputs hold; start = 1 SHALL restart as in REQ-016 (direct DONE -> RUN).
REQ-026 In IDLE and RUN, pass, fail, done SHALL be 0.

Reset
REQ-027 rst = 1 SHALL immediately force IDLE, busy/done/pass/fail = 0, err_count = 0, first_fail = 0, sweep_count = 0, exp_idx = 0, regardless of clock.
REQ-028 rst asserted mid-RUN SHALL discard the run; no partial result is reported.
REQ-029 On the first edge after rst deasserts, start SHALL be honoured normally.

Verification
REQ-030 Correct NAND, NUM_SWEEPS = 1, P = 0..15 with y = 1 except y = 0 at P = 15 -> DONE after 16th sample, pass = 1, err_count = 0, sweep_count = 1.
REQ-031 Same, but y forced 1 at P = 15 -> fail = 1, err_count = 1, first_fail = 4'hF.
REQ-032 Stuck-at-0 output (y = 0 always) -> err_count = 15, first_fail = 4'h0, fail = 1.
REQ-033 Patterns 0,1,3,2,4..15 with correct y -> err_count = 2, first_fail = 4'h3; valid gaps of 3 cycles between samples change nothing.
REQ-034 NUM_SWEEPS = 2, one y error at P = 5 in sweep 2 -> done only after 32 samples, err_count = 1, first_fail = 4'h5; then start -> outputs cleared, busy = 1 next cycle.
REQ-035 rst pulsed (asynchronously, between edges) after 7 samples -> all outputs 0 immediately, IDLE; start then full correct sweep -> pass = 1.
